// File: rtl/mem_stage_sequencer.sv
// In-order stage launcher and single-port memory arbiter with early abort.
// Optional per-stage watchdog enabled by defining MEM_STAGE_SEQUENCER_TIMEOUT_EN.
module mem_stage_sequencer #(
  parameter int                  N_STAGES       = 8,
  parameter int                  AW             = 16,
  parameter int                  DW             = 16,
  parameter logic [N_STAGES-1:0] WRITE_MASK     = {N_STAGES{1'b1}},
  parameter int                  IDX_W          = (N_STAGES > 1) ? $clog2(N_STAGES) : 1,
  parameter int                  TIMEOUT_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   run_start,
  output logic [N_STAGES-1:0]    start_o,
  input  logic [N_STAGES-1:0]    done_i,
  input  logic [N_STAGES-1:0]    abort_i,
  input  logic [N_STAGES*AW-1:0] stage_addr_i,
  input  logic [N_STAGES-1:0]    stage_wr_en_i,
  input  logic [N_STAGES*DW-1:0] stage_wdata_i,
  output logic [AW-1:0]          mem_addr,
  output logic                   mem_wr_en,
  output logic [DW-1:0]          mem_wdata,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   busy,
  output logic                   run_done,
  output logic                   aborted,
  output logic [IDX_W-1:0]       abort_stage,
  output logic                   timeout
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_STAGES - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             timeout_q;
  logic             cur_done;
  logic             cur_abort;
  logic             wd_hit;

  assign cur_done  = done_i[idx];
  assign cur_abort = abort_i[idx];

`ifdef MEM_STAGE_SEQUENCER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt;

  // Hit is flagged in the RUN cycle whose increment would reach the limit.
  assign wd_hit = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (en) begin
      if (state == LAUNCH)   wd_cnt <= '0;
      else if (state == RUN) wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wd_hit             = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      aborted     <= 1'b0;
      abort_stage <= '0;
      timeout_q   <= 1'b0;
    end else if (en) begin
      unique case (state)
        IDLE: begin
          if (run_start) begin
            state     <= LAUNCH;
            idx       <= '0;
            busy      <= 1'b1;
            aborted   <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        LAUNCH: state <= RUN;
        RUN: begin
          if (cur_done) begin
            if (cur_abort) begin
              aborted     <= 1'b1;
              abort_stage <= idx;
              state       <= FINISH;
            end else if (idx == LAST) begin
              state <= FINISH;
            end else begin
              idx   <= idx + 1'b1;
              state <= LAUNCH;
            end
          end else if (wd_hit) begin
            aborted     <= 1'b1;
            timeout_q   <= 1'b1;
            abort_stage <= idx;
            state       <= FINISH;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gating with en keeps a held LAUNCH/FINISH from producing repeated pulses.
  always_comb begin
    start_o   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr_en = 1'b0;
    if (state == LAUNCH && en) start_o[idx] = 1'b1;
    if (state == RUN) begin
      mem_addr  = stage_addr_i[int'(idx)*AW +: AW];
      mem_wdata = stage_wdata_i[int'(idx)*DW +: DW];
      mem_wr_en = stage_wr_en_i[idx] & WRITE_MASK[idx] & en;
    end
  end

  assign run_done  = (state == FINISH) && en;
  assign grant_idx = idx;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Directed bench for mem_stage_sequencer: 8 stages, stage 4 write-masked, 16-cycle watchdog.
module tb_mem_stage_sequencer;

  localparam int N  = 8;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          rst   = 1'b1;
  logic          en    = 1'b1;
  logic          run_start = 1'b0;
  logic [N-1:0]  start_o;
  logic [N-1:0]  done_i  = '0;
  logic [N-1:0]  abort_i = '0;
  logic [N*AW-1:0] stage_addr_i  = '0;
  logic [N-1:0]    stage_wr_en_i = '0;
  logic [N*DW-1:0] stage_wdata_i = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    grant_idx;
  logic          busy;
  logic          run_done;
  logic          aborted;
  logic [2:0]    abort_stage;
  logic          timeout;

  mem_stage_sequencer #(
    .N_STAGES(N), .AW(AW), .DW(DW), .WRITE_MASK(8'b1110_1111), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .rst(rst), .en(en), .run_start(run_start), .start_o(start_o),
    .done_i(done_i), .abort_i(abort_i), .stage_addr_i(stage_addr_i),
    .stage_wr_en_i(stage_wr_en_i), .stage_wdata_i(stage_wdata_i),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .grant_idx(grant_idx), .busy(busy), .run_done(run_done), .aborted(aborted),
    .abort_stage(abort_stage), .timeout(timeout)
  );

  always #5 clock = ~clock;

  int vec = 0;
  int errs = 0;
  int start_cnt[N];
  int rd_cnt, onehot_err, wr_dis;
  int order_q[$];
  bit resp_on = 1'b0;
  int resp_delay = 3;
  int abort_at = -1;
  int pend[N];

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Stage model: done_i[i] rises resp_delay cycles after start_o[i] is seen.
  initial forever begin
    @(posedge clock);
    #1;
    if (resp_on) begin
      done_i  = '0;
      abort_i = '0;
      for (int i = 0; i < N; i++)
        if (pend[i] > 0) begin
          pend[i]--;
          if (pend[i] == 0) begin
            done_i[i]  = 1'b1;
            abort_i[i] = (i == abort_at);
          end
        end
      for (int i = 0; i < N; i++)
        if (start_o[i]) pend[i] = resp_delay;
    end
  end

  initial forever begin
    @(negedge clock);
    if (start_o != '0) begin
      if (!$onehot(start_o)) onehot_err++;
      for (int i = 0; i < N; i++)
        if (start_o[i]) begin
          start_cnt[i]++;
          order_q.push_back(i);
        end
    end
    if (run_done) rd_cnt++;
    if (mem_wr_en && !en) wr_dis++;
  end

  task automatic clear_mon();
    for (int i = 0; i < N; i++) begin
      start_cnt[i] = 0;
      pend[i] = 0;
    end
    rd_cnt = 0;
    onehot_err = 0;
    wr_dis = 0;
    order_q.delete();
  endtask

  task automatic pulse_run_start();
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
  endtask

  task automatic wait_start(input int s);
    int cnt = 0;
    while (!start_o[s] && cnt < 60) begin
      tick();
      cnt++;
    end
    vec++;
    if (start_o[s] !== 1'b1) begin
      errs++;
      $display("FAIL wait_start[%0d]: start_o=%b required bit %0d high within 60 cycles", s, start_o, s);
    end
  endtask

  task automatic finish_stage(input int s);
    wait_start(s);
    tick();
    done_i[s] = 1'b1;
    tick();
    done_i[s] = 1'b0;
  endtask

  task automatic wait_run_done();
    int cnt = 0;
    while (!run_done && cnt < 200) begin
      tick();
      cnt++;
    end
    vec++;
    if (run_done !== 1'b1) begin
      errs++;
      $display("FAIL wait_run_done: run_done=%b required 1 within 200 cycles", run_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vec++;
    if ({start_o, busy, run_done, mem_wr_en} !== '0) begin
      errs++;
      $display("FAIL reset_ctrl: start_o=%h busy=%b run_done=%b mem_wr_en=%b required all 0",
               start_o, busy, run_done, mem_wr_en);
    end
    vec++;
    if ({aborted, timeout, grant_idx, abort_stage} !== '0) begin
      errs++;
      $display("FAIL reset_status: aborted=%b timeout=%b grant_idx=%0d abort_stage=%0d required 0",
               aborted, timeout, grant_idx, abort_stage);
    end
    vec++;
    if ({mem_addr, mem_wdata} !== '0) begin
      errs++;
      $display("FAIL reset_mem: mem_addr=%h mem_wdata=%h required 0", mem_addr, mem_wdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_run();
    int busy_low = 0;
    int cnt = 0;
    bit ok;
    clear_mon();
    resp_delay = 3;
    abort_at = -1;
    resp_on = 1'b1;
    pulse_run_start();
    while (!run_done && cnt < 200) begin
      if (!busy) busy_low++;
      run_start = (cnt == 10);
      tick();
      cnt++;
    end
    run_start = 1'b0;
    vec++;
    if (run_done !== 1'b1) begin
      errs++;
      $display("FAIL full_run_done: run_done=%b required 1 within 200 cycles", run_done);
    end
    vec++;
    if (busy !== 1'b1 || busy_low != 0) begin
      errs++;
      $display("FAIL full_busy: busy=%b low_cycles=%0d required busy=1 low_cycles=0", busy, busy_low);
    end
    vec++;
    if (aborted !== 1'b0) begin
      errs++;
      $display("FAIL full_aborted: aborted=%b required 0", aborted);
    end
    tick();
    vec++;
    if (busy !== 1'b0 || run_done !== 1'b0) begin
      errs++;
      $display("FAIL full_after: busy=%b run_done=%b required 0 0", busy, run_done);
    end
    repeat (5) tick();
    ok = (order_q.size() == N);
    for (int i = 0; i < N && ok; i++) if (order_q[i] != i) ok = 1'b0;
    vec++;
    if (!ok) begin
      errs++;
      $display("FAIL full_order: %0d pulses, order %p required 0..7 once each", order_q.size(), order_q);
    end
    vec++;
    if (rd_cnt != 1 || onehot_err != 0) begin
      errs++;
      $display("FAIL full_pulses: run_done_count=%0d onehot_errors=%0d required 1 0", rd_cnt, onehot_err);
    end
    resp_on = 1'b0;
    done_i = '0;
  endtask

  task automatic test_latency();
    int k;
    clear_mon();
    resp_delay = 1;
    abort_at = -1;
    resp_on = 1'b1;
    pulse_run_start();
    k = 1;
    vec++;
    if (start_o !== 8'h01) begin
      errs++;
      $display("FAIL lat_first_start: start_o=%h at cycle 1 required 01", start_o);
    end
    while (!run_done && k < 100) begin
      tick();
      k++;
    end
    vec++;
    if (k != 2 * N + 1) begin
      errs++;
      $display("FAIL lat_run_done: run_done at cycle %0d required %0d", k, 2 * N + 1);
    end
    tick();
    tick();
    resp_on = 1'b0;
    done_i = '0;
  endtask

  task automatic test_abort();
    int k = 0;
    int kab = -100;
    int krd = -1;
    int late = 0;
    clear_mon();
    resp_delay = 3;
    abort_at = 1;
    resp_on = 1'b1;
    pulse_run_start();
    while (k < 100) begin
      if (done_i[1] && abort_i[1]) kab = k;
      if (run_done) begin
        krd = k;
        break;
      end
      tick();
      k++;
    end
    vec++;
    if (krd != kab + 1) begin
      errs++;
      $display("FAIL abort_latency: run_done at %0d, abort seen at %0d, required one cycle later", krd, kab);
    end
    vec++;
    if (aborted !== 1'b1 || abort_stage !== 3'd1 || timeout !== 1'b0) begin
      errs++;
      $display("FAIL abort_status: aborted=%b abort_stage=%0d timeout=%b required 1 1 0",
               aborted, abort_stage, timeout);
    end
    repeat (6) tick();
    for (int i = 2; i < N; i++) late += start_cnt[i];
    vec++;
    if (start_cnt[0] != 1 || start_cnt[1] != 1 || late != 0) begin
      errs++;
      $display("FAIL abort_starts: s0=%0d s1=%0d s2..7=%0d required 1 1 0", start_cnt[0], start_cnt[1], late);
    end
    vec++;
    if (aborted !== 1'b1 || rd_cnt != 1) begin
      errs++;
      $display("FAIL abort_sticky: aborted=%b run_done_count=%0d required 1 1", aborted, rd_cnt);
    end
    resp_on = 1'b0;
    abort_at = -1;
    done_i = '0;
    abort_i = '0;
  endtask

  task automatic test_write_mask();
    clear_mon();
    for (int i = 0; i < N; i++) begin
      stage_addr_i[i*AW +: AW]  = 16'h1000 + 16'(i);
      stage_wdata_i[i*DW +: DW] = 16'hA000 + 16'(i);
    end
    stage_wr_en_i = 8'b0011_0000;
    stage_addr_i[4*AW +: AW]  = 16'h0148;
    stage_wdata_i[4*DW +: DW] = 16'hBEEF;
    stage_addr_i[5*AW +: AW]  = 16'h0668;
    stage_wdata_i[5*DW +: DW] = 16'h0003;
    pulse_run_start();
    vec++;
    if (aborted !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL mask_accept: aborted=%b busy=%b required 0 1", aborted, busy);
    end
    for (int s = 0; s < 4; s++) finish_stage(s);
    wait_start(4);
    tick();
    vec++;
    if (grant_idx !== 3'd4 || mem_addr !== 16'h0148 || mem_wr_en !== 1'b0) begin
      errs++;
      $display("FAIL mask_stage4: grant=%0d addr=%h wr_en=%b required 4 0148 0", grant_idx, mem_addr, mem_wr_en);
    end
    done_i[4] = 1'b1;
    tick();
    done_i[4] = 1'b0;
    vec++;
    if (mem_wr_en !== 1'b0 || mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) begin
      errs++;
      $display("FAIL mask_launch_idle: wr_en=%b addr=%h data=%h required 0 0000 0000", mem_wr_en, mem_addr, mem_wdata);
    end
    tick();
    vec++;
    if (grant_idx !== 3'd5 || mem_wr_en !== 1'b1 || mem_addr !== 16'h0668 || mem_wdata !== 16'h0003) begin
      errs++;
      $display("FAIL mask_stage5: grant=%0d wr_en=%b addr=%h data=%h required 5 1 0668 0003",
               grant_idx, mem_wr_en, mem_addr, mem_wdata);
    end
    done_i[5] = 1'b1;
    tick();
    done_i[5] = 1'b0;
    finish_stage(6);
    finish_stage(7);
    wait_run_done();
    tick();
    stage_wr_en_i = '0;
  endtask

  task automatic test_en();
    clear_mon();
    stage_wr_en_i = 8'b0000_0100;
    stage_addr_i[2*AW +: AW]  = 16'h0222;
    stage_wdata_i[2*DW +: DW] = 16'h5555;
    pulse_run_start();
    finish_stage(0);
    finish_stage(1);
    wait_start(2);
    tick();
    en = 1'b0;
    for (int j = 0; j < 5; j++) begin
      done_i[2] = (j == 2);
      #1;
      vec++;
      if (mem_wr_en !== 1'b0 || start_o !== '0 || grant_idx !== 3'd2) begin
        errs++;
        $display("FAIL en_frozen[%0d]: wr_en=%b start_o=%h grant=%0d required 0 00 2", j, mem_wr_en, start_o, grant_idx);
      end
      tick();
    end
    done_i[2] = 1'b0;
    en = 1'b1;
    #1;
    vec++;
    if (mem_wr_en !== 1'b1 || mem_addr !== 16'h0222 || start_o !== '0 || grant_idx !== 3'd2) begin
      errs++;
      $display("FAIL en_resume: wr_en=%b addr=%h start_o=%h grant=%0d required 1 0222 00 2",
               mem_wr_en, mem_addr, start_o, grant_idx);
    end
    done_i[2] = 1'b1;
    tick();
    done_i[2] = 1'b0;
    en = 1'b0;
    #1;
    vec++;
    if (start_o !== '0) begin
      errs++;
      $display("FAIL en_launch_hold: start_o=%h required 00", start_o);
    end
    tick();
    tick();
    en = 1'b1;
    #1;
    vec++;
    if (start_o !== 8'h08 || grant_idx !== 3'd3) begin
      errs++;
      $display("FAIL en_launch_fire: start_o=%h grant=%0d required 08 3", start_o, grant_idx);
    end
    tick();
    done_i[3] = 1'b1;
    tick();
    done_i[3] = 1'b0;
    for (int s = 4; s < N; s++) finish_stage(s);
    wait_run_done();
    tick();
    vec++;
    if (start_cnt[2] != 1 || start_cnt[3] != 1 || rd_cnt != 1 || wr_dis != 0) begin
      errs++;
      $display("FAIL en_counts: s2=%0d s3=%0d run_done=%0d wr_while_disabled=%0d required 1 1 1 0",
               start_cnt[2], start_cnt[3], rd_cnt, wr_dis);
    end
    stage_wr_en_i = '0;
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    bit ok;
    clear_mon();
    resp_delay = 3;
    abort_at = -1;
    resp_on = 1'b1;
    pulse_run_start();
    while (grant_idx !== 3'd3 && cnt < 100) begin
      tick();
      cnt++;
    end
    resp_on = 1'b0;
    done_i = '0;
    abort_i = '0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    rst = 1'b1;
    tick();
    vec++;
    if (busy !== 1'b0 || start_o !== '0 || grant_idx !== 3'd0 || run_done !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_state: busy=%b start_o=%h grant=%0d run_done=%b required 0 00 0 0",
               busy, start_o, grant_idx, run_done);
    end
    rst = 1'b0;
    repeat (4) tick();
    vec++;
    if (rd_cnt != 0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_no_done: run_done_count=%0d busy=%b required 0 0", rd_cnt, busy);
    end
    clear_mon();
    resp_on = 1'b1;
    pulse_run_start();
    vec++;
    if (start_o !== 8'h01) begin
      errs++;
      $display("FAIL rstmid_restart: start_o=%h required 01", start_o);
    end
    wait_run_done();
    repeat (3) tick();
    ok = (order_q.size() == N);
    for (int i = 0; i < N && ok; i++) if (order_q[i] != i) ok = 1'b0;
    vec++;
    if (!ok || rd_cnt != 1) begin
      errs++;
      $display("FAIL rstmid_rerun: %0d pulses order %p run_done=%0d required 0..7 and 1", order_q.size(), order_q, rd_cnt);
    end
    resp_on = 1'b0;
    done_i = '0;
  endtask

`ifdef MEM_STAGE_SEQUENCER_TIMEOUT_EN
  task automatic test_timeout();
    int k = 0;
    clear_mon();
    pulse_run_start();
    vec++;
    if (start_o !== 8'h01) begin
      errs++;
      $display("FAIL to_start: start_o=%h required 01", start_o);
    end
    while (!run_done && k < 60) begin
      tick();
      k++;
    end
    vec++;
    if (k != 17) begin
      errs++;
      $display("FAIL to_latency: run_done %0d cycles after start_o[0] required 17", k);
    end
    vec++;
    if (timeout !== 1'b1 || aborted !== 1'b1 || abort_stage !== 3'd0) begin
      errs++;
      $display("FAIL to_status: timeout=%b aborted=%b abort_stage=%0d required 1 1 0", timeout, aborted, abort_stage);
    end
    tick();
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL global_time_limit: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_run();
    test_latency();
    test_abort();
    test_write_mask();
    test_en();
    test_reset_mid();
`ifdef MEM_STAGE_SEQUENCER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
